// File: rtl/mc_datapath_v2.sv
// Multicycle CPU datapath: PC/IR/MDR/ALUOut/output registers, 4-entry register file, req/ack memory port.
// Optional performance counters (retired, stall_cycles) are built when MC_DATAPATH_PERF_EN is defined.
module mc_datapath_v2 #(
    parameter int               WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] PC_RESET  = '0,
    parameter logic [1:0]       LINK_REG  = 2'd2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic [1:0]           pc_source,
    input  logic                 alu_src_a,
    input  logic [1:0]           alu_src_b,
    input  logic [2:0]           alu_ctl,
    input  logic [1:0]           branch_type,
    input  logic                 reg_write,
    input  logic [1:0]           reg_dst,
    input  logic                 mem_to_reg,
    input  logic                 iord,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 ir_write,
    input  logic                 out_write,
    input  logic                 halt,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 stall,
    output logic [3:0]           opcode,
    output logic [5:0]           func,
    output logic                 bcond,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] output_reg,
    output logic                 is_halted
`ifdef MC_DATAPATH_PERF_EN
    ,
    output logic [31:0]          retired,
    output logic [31:0]          stall_cycles
`endif
);
    typedef enum logic [0:0] {MEM_IDLE = 1'b0, MEM_REQ = 1'b1} mem_state_t;

    mem_state_t           state_r, state_nxt_s;
    logic [WORD_SIZE-1:0] pc_r, mdr_r, alu_out_r, out_r, addr_lat_r, wdata_lat_r;
    logic [WORD_SIZE-1:0] gpr_r [4];
    logic [15:0]          ir_r;
    logic                 halted_r, we_lat_r, to_ir_lat_r;
    logic                 start_s, req_s, we_s, stall_s, capture_s, cap_ir_s;
    logic [WORD_SIZE-1:0] addr_s, wdata_s, rs_val_s, rt_val_s, alu_a_s, alu_b_s, alu_res_s;
    logic [WORD_SIZE-1:0] pc_nxt_s, wb_s;
    logic [1:0]           wr_idx_s;
    logic                 bcond_s, pc_en_s;

    assign rs_val_s = gpr_r[ir_r[11:10]];
    assign rt_val_s = gpr_r[ir_r[9:8]];
    assign start_s  = (mem_read | mem_write) & ~halted_r;

    // Memory FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= MEM_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Memory FSM next state; a same-cycle ack never leaves IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MEM_IDLE: if (start_s && !mem_ack) state_nxt_s = MEM_REQ; else state_nxt_s = MEM_IDLE;
            MEM_REQ:  if (mem_ack) state_nxt_s = MEM_IDLE; else state_nxt_s = MEM_REQ;
            default:  state_nxt_s = MEM_IDLE;
        endcase
    end

    // Memory FSM outputs: IDLE drives live values, REQ replays the latched request
    always_comb begin
        req_s = 1'b0; we_s = 1'b0; addr_s = pc_r; wdata_s = rt_val_s;
        stall_s = 1'b0; capture_s = 1'b0; cap_ir_s = 1'b0;
        case (state_r)
            MEM_IDLE: begin
                req_s     = start_s;
                we_s      = start_s & mem_write;
                addr_s    = iord ? alu_out_r : pc_r;
                stall_s   = start_s & ~mem_ack;
                capture_s = start_s & mem_ack & ~mem_write;
                cap_ir_s  = ir_write;
            end
            MEM_REQ: begin
                req_s     = 1'b1;
                we_s      = we_lat_r;
                addr_s    = addr_lat_r;
                wdata_s   = wdata_lat_r;
                stall_s   = ~mem_ack;
                capture_s = mem_ack & ~we_lat_r;
                cap_ir_s  = to_ir_lat_r;
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
    end

    // Request latch captured when a transfer leaves IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_lat_r <= '0; wdata_lat_r <= '0; we_lat_r <= 1'b0; to_ir_lat_r <= 1'b0;
        end else if (state_r == MEM_IDLE && start_s) begin
            addr_lat_r  <= iord ? alu_out_r : pc_r;
            wdata_lat_r <= rt_val_s;
            we_lat_r    <= mem_write;
            to_ir_lat_r <= ir_write;
        end
    end

    // ALU operand selection, ALU, branch condition, PC/writeback muxes
    always_comb begin
        alu_a_s = alu_src_a ? rs_val_s : pc_r;
        case (alu_src_b)
            2'd0:    alu_b_s = rt_val_s;
            2'd1:    alu_b_s = {{(WORD_SIZE-1){1'b0}}, 1'b1};
            2'd2:    alu_b_s = {{(WORD_SIZE-8){ir_r[7]}}, ir_r[7:0]};
            default: alu_b_s = {{(WORD_SIZE-8){1'b0}}, ir_r[7:0]};
        endcase
        case (alu_ctl)
            3'd0:    alu_res_s = alu_a_s + alu_b_s;
            3'd1:    alu_res_s = alu_a_s - alu_b_s;
            3'd2:    alu_res_s = alu_a_s & alu_b_s;
            3'd3:    alu_res_s = alu_a_s | alu_b_s;
            3'd4:    alu_res_s = ~alu_a_s;
            3'd5:    alu_res_s = '0 - alu_a_s;
            3'd6:    alu_res_s = {alu_a_s[WORD_SIZE-2:0], 1'b0};
            default: alu_res_s = {alu_a_s[WORD_SIZE-1], alu_a_s[WORD_SIZE-1:1]};
        endcase
        case (branch_type)
            2'd0:    bcond_s = (rs_val_s != rt_val_s);
            2'd1:    bcond_s = (rs_val_s == rt_val_s);
            2'd2:    bcond_s = ~rs_val_s[WORD_SIZE-1] & (rs_val_s != '0);
            default: bcond_s = rs_val_s[WORD_SIZE-1];
        endcase
        case (pc_source)
            2'd0:    pc_nxt_s = alu_res_s;
            2'd1:    pc_nxt_s = alu_out_r;
            2'd2:    pc_nxt_s = {pc_r[WORD_SIZE-1:12], ir_r[11:0]};
            default: pc_nxt_s = rs_val_s;
        endcase
        case (reg_dst)
            2'd0:    wr_idx_s = ir_r[9:8];
            2'd1:    wr_idx_s = ir_r[7:6];
            2'd2:    wr_idx_s = LINK_REG;
            default: wr_idx_s = ir_r[9:8];
        endcase
        wb_s    = mem_to_reg ? mdr_r : alu_out_r;
        pc_en_s = (pc_write | (pc_write_cond & bcond_s)) & ~stall_s & ~halted_r;
    end

    // Architectural registers; stalls suppress every write except memory capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r <= PC_RESET; ir_r <= 16'h0000; mdr_r <= '0; alu_out_r <= '0;
            out_r <= '0; halted_r <= 1'b0;
            for (int i = 0; i < 4; i++) gpr_r[i] <= '0;
        end else begin
            if (pc_en_s) pc_r <= pc_nxt_s;
            if (!stall_s) alu_out_r <= alu_res_s;
            if (capture_s && cap_ir_s) ir_r <= mem_rdata[15:0];
            else if (capture_s) mdr_r <= mem_rdata;
            if (reg_write && !stall_s && !halted_r) gpr_r[wr_idx_s] <= wb_s;
            if (out_write && !stall_s) out_r <= rs_val_s;
            if (halt) halted_r <= 1'b1;
        end
    end

`ifdef MC_DATAPATH_PERF_EN
    // Saturating fetch-retire and stall counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= 32'd0; stall_cycles <= 32'd0;
        end else begin
            if (capture_s && cap_ir_s && !stall_s && retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
            if (stall_s && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    assign mem_req    = req_s;
    assign mem_we     = we_s;
    assign mem_addr   = addr_s;
    assign mem_wdata  = wdata_s;
    assign stall      = stall_s;
    assign opcode     = ir_r[15:12];
    assign func       = ir_r[5:0];
    assign bcond      = bcond_s;
    assign pc         = pc_r;
    assign output_reg = out_r;
    assign is_halted  = halted_r;
endmodule
